mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
//   Sits between ifu/mem and the single SRAM/bus port when the core runs multi-cycle with a unified memory.
//   Allows one outstanding transaction. Grants by fixed priority (LSU first by default).
//   Returns each response only to the requester that owns it.
// PARAMETERS
//   XLEN      32  data/address width; must be a multiple of 8
//   LSU_PRIO  1   1: LSU wins simultaneous requests; 0: IFU wins
// PORTS
//   clk_i            in   1       clock; all state changes on the rising edge
//   rst_ni           in   1       asynchronous, active-low reset
//   ifu_req_valid_i  in   1       IFU fetch request
//   ifu_req_ready_o  out  1       IFU request accepted this cycle
//   ifu_addr_i       in   XLEN    fetch address
//   ifu_rsp_valid_o  out  1       fetch data valid (1-cycle pulse)
//   ifu_rdata_o      out  XLEN    fetched instruction
//   lsu_req_valid_i  in   1       LSU request
//   lsu_req_ready_o  out  1       LSU request accepted this cycle
//   lsu_addr_i       in   XLEN    load/store address
//   lsu_wen_i        in   1       1 = store, 0 = load
//   lsu_wdata_i      in   XLEN    store data
//   lsu_wstrb_i      in   XLEN/8  store byte enables
//   lsu_rsp_valid_o  out  1       LSU response valid (1-cycle pulse); also sent for stores
//   lsu_rdata_o      out  XLEN    load data
//   rsp_err_o        out  1       error flag of the current response; qualify with either rsp_valid
//   mem_req_valid_o  out  1       request to memory
//   mem_req_ready_i  in   1       memory accepts request
//   mem_addr_o       out  XLEN    latched address
//   mem_wen_o        out  1       latched write enable
//   mem_wdata_o      out  XLEN    latched write data
//   mem_wstrb_o      out  XLEN/8  latched byte enables; 0 for every IFU request
//   mem_rsp_valid_i  in   1       memory response valid
//   mem_rdata_i      in   XLEN    memory read data
//   mem_rsp_err_i    in   1       memory error
// BEHAVIOUR
//   FSM states: IDLE, REQ, RSP. Owner register: IFU or LSU.
//   Reset: state=IDLE, owner=IFU, all latched fields 0, and all valid/ready outputs 0.
//   IDLE: *_req_ready_o is combinational. Only the winner sees ready=1 in a cycle where at least one valid is high.
//     In that cycle the arbiter latches addr/wen/wdata/wstrb and the owner, and moves to REQ.
//   Both valids high: LSU_PRIO selects the winner. The loser keeps valid high and is served after RSP; it is never dropped.
//   REQ: mem_req_valid_o=1 from registered fields. Stays in REQ until mem_req_ready_i=1, then moves to RSP.
//     Latched fields do not change while in REQ.
//   RSP: waits for mem_rsp_valid_i. In the cycle it is high, the arbiter:
//     - routes mem_rdata_i and mem_rsp_err_i combinationally to the owner only;
//     - pulses that owner's rsp_valid for 1 cycle;
//     - returns to IDLE.
//     The non-owner's rsp_valid stays 0.
//   Minimum latency from request acceptance to response: 2 cycles (accept in IDLE, memory ready in REQ, response in RSP).
//   While not in IDLE, both req_ready outputs are 0 and new requests are held off.
//   A mem_rsp_valid_i that arrives outside RSP is ignored. Verification flags it as a protocol error.
//   Asynchronous reset during REQ or RSP: return to IDLE at once. The pending response is discarded, and no rsp_valid is emitted afterwards.
//   No fairness counter. With LSU_PRIO=1, the IFU can be starved only while the LSU requests back-to-back.
// STRUCTURE
//   Add to defines.v: `ARB_IDLE/`ARB_REQ/`ARB_RSP (2-bit encodings), `OWN_IFU/`OWN_LSU.
//   One sub-module: arb_pick, a combinational 2-way fixed-priority picker (valids, prio -> grant one-hot).
//   Everything else stays in mem_arbiter: FSM, latch registers, response steering.
// TESTING
//   1. IFU only: addr 0x80000000, mem ready same cycle, rdata 0x00100073 one cycle later
//      -> ifu_rsp_valid_o pulses with 0x00100073; lsu_rsp_valid_o stays 0.
//   2. Simultaneous IFU 0x80000004 and LSU store 0x80001000 (data 0xDEADBEEF, strb 0xF), LSU_PRIO=1
//      -> the store reaches memory first; the IFU request reaches memory next; each response goes only to its owner.
//   3. Memory stalls mem_req_ready_i for 5 cycles -> mem_req_valid_o and the latched fields stay constant; both req_ready outputs stay 0.
//   4. rst_ni low while in RSP -> state IDLE; a later mem_rsp_valid_i produces no rsp_valid; the next request is served normally.
//   5. LSU load with mem_rsp_err_i=1 -> lsu_rsp_valid_o=1 and rsp_err_o=1 in the same cycle; IFU unaffected.
//   6. LSU_PRIO=0, back-to-back IFU requests with the LSU waiting -> the LSU is granted only when the IFU valid drops.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbReq  = 2'd1,
    ArbRsp  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } arb_owner_e;

  // Bit positions inside the requester valid/grant vectors
  localparam int unsigned GrantIfu = 0;
  localparam int unsigned GrantLsu = 1;

  // Map a one-hot grant to the owner that will hold the memory port
  function automatic arb_owner_e grant_owner(input logic [1:0] gnt);
    return gnt[GrantLsu] ? OwnLsu : OwnIfu;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way fixed-priority picker: valids plus priority select -> one-hot grant.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       prio_lsu_i,
  output logic [1:0] grant_o
);

  // LSU wins when it has priority or when the IFU is not asking
  always_comb begin
    grant_o = '0;
    if (valid_i[GrantLsu] && (prio_lsu_i || !valid_i[GrantIfu])) begin
      grant_o[GrantLsu] = 1'b1;
    end else if (valid_i[GrantIfu]) begin
      grant_o[GrantIfu] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single memory port between the IFU (read-only) and the LSU (read/write).
// One outstanding transaction; responses are steered only to the requester that owns it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          LSU_PRIO = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [XLEN-1:0]   ifu_addr_i,
  output logic              ifu_rsp_valid_o,
  output logic [XLEN-1:0]   ifu_rdata_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic              lsu_wen_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic [XLEN/8-1:0] lsu_wstrb_i,
  output logic              lsu_rsp_valid_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_wen_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_rsp_err_i
);

  localparam int unsigned StrbW = XLEN / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic [XLEN-1:0]   addr_q;
  logic              wen_q;
  logic [XLEN-1:0]   wdata_q;
  logic [StrbW-1:0]  wstrb_q;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       accept;
  logic       rsp_fire;

  assign req_valid[GrantIfu] = ifu_req_valid_i;
  assign req_valid[GrantLsu] = lsu_req_valid_i;

  arb_pick u_arb_pick (
    .valid_i    (req_valid),
    .prio_lsu_i (LSU_PRIO),
    .grant_o    (grant)
  );

  assign accept   = (state_q == ArbIdle) && (grant != 2'b00);
  assign rsp_fire = (state_q == ArbRsp) && mem_rsp_valid_i;

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, hand-shake in REQ, wait for data in RSP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: if (accept)          state_d = ArbReq;
      ArbReq:  if (mem_req_ready_i) state_d = ArbRsp;
      ArbRsp:  if (mem_rsp_valid_i) state_d = ArbIdle;
      default:                      state_d = ArbIdle;
    endcase
  end

  // Capture the winning request; fields hold steady until the next acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= OwnIfu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      owner_q <= grant_owner(grant);
      if (grant[GrantLsu]) begin
        addr_q  <= lsu_addr_i;
        wen_q   <= lsu_wen_i;
        wdata_q <= lsu_wdata_i;
        wstrb_q <= lsu_wstrb_i;
      end else begin
        // Fetches are plain reads with no byte enables
        addr_q  <= ifu_addr_i;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  // Outputs: ready only in IDLE to the winner, response steered to the owner
  always_comb begin
    ifu_req_ready_o = (state_q == ArbIdle) && grant[GrantIfu];
    lsu_req_ready_o = (state_q == ArbIdle) && grant[GrantLsu];
    mem_req_valid_o = (state_q == ArbReq);
    mem_addr_o      = addr_q;
    mem_wen_o       = wen_q;
    mem_wdata_o     = wdata_q;
    mem_wstrb_o     = wstrb_q;
    ifu_rsp_valid_o = rsp_fire && (owner_q == OwnIfu);
    lsu_rsp_valid_o = rsp_fire && (owner_q == OwnLsu);
    ifu_rdata_o     = ifu_rsp_valid_o ? mem_rdata_i : '0;
    lsu_rdata_o     = lsu_rsp_valid_o ? mem_rdata_i : '0;
    rsp_err_o       = rsp_fire && mem_rsp_err_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
// dut uses LSU priority; dut0 (IFU priority) shares the same inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req_valid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rsp_err = 1'b0;

  logic        ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid, rsp_err;
  logic        mem_req_valid, mem_wen;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        d0_ifu_req_ready, d0_ifu_rsp_valid, d0_lsu_req_ready, d0_lsu_rsp_valid;
  logic        d0_rsp_err, d0_mem_req_valid, d0_mem_wen;
  logic [31:0] d0_ifu_rdata, d0_lsu_rdata, d0_mem_addr, d0_mem_wdata;
  logic [3:0]  d0_mem_wstrb;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        own_lsu;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .LSU_PRIO(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready), .ifu_addr_i(ifu_addr),
    .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_addr_i(lsu_addr),
    .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb),
    .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rdata_o(lsu_rdata), .rsp_err_o(rsp_err),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
    .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata), .mem_rsp_err_i(mem_rsp_err)
  );

  mem_arbiter #(.XLEN(32), .LSU_PRIO(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(d0_ifu_req_ready), .ifu_addr_i(ifu_addr),
    .ifu_rsp_valid_o(d0_ifu_rsp_valid), .ifu_rdata_o(d0_ifu_rdata),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(d0_lsu_req_ready), .lsu_addr_i(lsu_addr),
    .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb),
    .lsu_rsp_valid_o(d0_lsu_rsp_valid), .lsu_rdata_o(d0_lsu_rdata), .rsp_err_o(d0_rsp_err),
    .mem_req_valid_o(d0_mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(d0_mem_addr), .mem_wen_o(d0_mem_wen), .mem_wdata_o(d0_mem_wdata),
    .mem_wstrb_o(d0_mem_wstrb),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata), .mem_rsp_err_i(mem_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the readies in the current IDLE cycle, then step past the accepting edge
  task automatic accept(input string tag, input logic exp_ifu, input logic exp_lsu);
    @(negedge clk);
    chk({tag, " ifu_ready"}, ifu_req_ready, exp_ifu);
    chk({tag, " lsu_ready"}, lsu_req_ready, exp_lsu);
    @(posedge clk); #1;
  endtask

  // Drive one memory transaction on dut (called just after acceptance) and score the response
  task automatic serve(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] ws, input int stall);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s sb_empty: observed=0 entries expected>=1", tag);
      return;
    end
    e = sb[0];
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk({tag, " stall_valid"}, mem_req_valid, 1'b1);
      chk({tag, " stall_addr"}, mem_addr, a);
      chk({tag, " stall_wdata"}, mem_wdata, wd);
      chk({tag, " stall_ifu_rdy"}, ifu_req_ready, 1'b0);
      chk({tag, " stall_lsu_rdy"}, lsu_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk({tag, " req_valid"}, mem_req_valid, 1'b1);
    chk({tag, " addr"}, mem_addr, a);
    chk({tag, " wen"}, mem_wen, w);
    chk({tag, " wdata"}, mem_wdata, wd);
    chk({tag, " wstrb"}, mem_wstrb, ws);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = e.data;
    mem_rsp_err   = e.err;
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " req_valid_rsp"}, mem_req_valid, 1'b0);
    chk({tag, " ifu_rsp_valid"}, ifu_rsp_valid, !e.own_lsu);
    chk({tag, " lsu_rsp_valid"}, lsu_rsp_valid, e.own_lsu);
    if (e.own_lsu) chk({tag, " lsu_rdata"}, lsu_rdata, e.data);
    else           chk({tag, " ifu_rdata"}, ifu_rdata, e.data);
    chk({tag, " rsp_err"}, rsp_err, e.err);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic push(input logic own_lsu, input logic [31:0] data, input logic err);
    exp_t e;
    e.own_lsu = own_lsu;
    e.data    = data;
    e.err     = err;
    sb.push_back(e);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ifu_ready", ifu_req_ready, 1'b0);
    chk("rst lsu_ready", lsu_req_ready, 1'b0);
    chk("rst mem_valid", mem_req_valid, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wen", mem_wen, 1'b0);
    chk("rst mem_wstrb", mem_wstrb, 4'h0);
    chk("rst ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("rst lsu_rsp", lsu_rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: IFU only
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    push(1'b0, 32'h0010_0073, 1'b0);
    accept("t1", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    serve("t1", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0);

    // 2: simultaneous IFU fetch and LSU store; LSU first
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wstrb     = 4'hF;
    push(1'b1, 32'h0, 1'b0);
    push(1'b0, 32'h0000_0013, 1'b0);
    accept("t2a", 1'b0, 1'b1);
    lsu_req_valid = 1'b0;
    serve("t2a", 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    accept("t2b", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    serve("t2b", 32'h8000_0004, 1'b0, 32'h0, 4'h0, 0);

    // 3: LSU load stalled 5 cycles; IFU waits behind it and is not dropped
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_0100;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h1111_2222;
    lsu_wstrb     = 4'h3;
    push(1'b1, 32'hCAFE_F00D, 1'b0);
    push(1'b0, 32'h0000_0093, 1'b0);
    accept("t3a", 1'b0, 1'b1);
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    serve("t3a", 32'h0000_0100, 1'b0, 32'h1111_2222, 4'h3, 5);
    accept("t3b", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    serve("t3b", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0);

    // 4: reset while in RSP; a late memory response must not surface
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    accept("t4", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4 rst mem_valid", mem_req_valid, 1'b0);
    chk("t4 rst mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0BAD;
    @(negedge clk);
    chk("t4 stale ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("t4 stale lsu_rsp", lsu_rsp_valid, 1'b0);
    chk("t4 stale mem_valid", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_000C;
    push(1'b0, 32'h0000_1234, 1'b0);
    accept("t4b", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    serve("t4b", 32'h8000_000C, 1'b0, 32'h0, 4'h0, 0);

    // 5: LSU load answered with an error
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_0200;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wstrb     = 4'h0;
    push(1'b1, 32'h1234_5678, 1'b1);
    accept("t5", 1'b0, 1'b1);
    lsu_req_valid = 1'b0;
    serve("t5", 32'h0000_0200, 1'b0, 32'h0, 4'h0, 1);

    // 6: IFU priority (dut0); LSU waits until IFU valid drops
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_0300;
    lsu_wen       = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h9000_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6 d0_ifu_ready", d0_ifu_req_ready, 1'b1);
      chk("t6 d0_lsu_ready", d0_lsu_req_ready, 1'b0);
      @(posedge clk); #1;
      ifu_addr = ifu_addr + 32'd4;
      if (k == 2) ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("t6 d0_mem_addr", d0_mem_addr, 32'h9000_0000 + 32'(4 * k));
      chk("t6 d0_lsu_ready_busy", d0_lsu_req_ready, 1'b0);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'(k + 1);
      @(negedge clk);
      chk("t6 d0_ifu_rsp", d0_ifu_rsp_valid, 1'b1);
      chk("t6 d0_ifu_rdata", d0_ifu_rdata, 32'(k + 1));
      chk("t6 d0_lsu_rsp", d0_lsu_rsp_valid, 1'b0);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
    end
    @(negedge clk);
    chk("t6 d0_lsu_ready_last", d0_lsu_req_ready, 1'b1);
    chk("t6 d0_ifu_ready_last", d0_ifu_req_ready, 1'b0);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t6 d0_lsu_addr", d0_mem_addr, 32'h0000_0300);
    chk("t6 d0_lsu_wstrb", d0_mem_wstrb, 4'h0);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_5555;
    @(negedge clk);
    chk("t6 d0_lsu_rsp", d0_lsu_rsp_valid, 1'b1);
    chk("t6 d0_lsu_rdata", d0_lsu_rdata, 32'h0000_5555);
    chk("t6 d0_ifu_rsp_last", d0_ifu_rsp_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
